// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and index helpers for the 8-point FFT/IFFT cores.
package fft_pkg;

    localparam int N               = 8;
    localparam int LOG2N           = 3;
    localparam int DATA_W          = 32;
    localparam int OUT_W           = 21;
    localparam int SCALE_SHIFT     = 3;
    localparam int INV_SQRT2_NUM   = 181;
    localparam int INV_SQRT2_SHIFT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } fft_state_t;

    function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

endpackage

// File: rtl/fft_bfly_r2.sv
// Combinational radix-2 DIF butterfly: top = a+b, bot = (a-b)*W with W from a 2-bit index.
module fft_bfly_r2 #(
    parameter int DW = 32
) (
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic        [1:0]    tw_idx,
    input  logic                 inverse,
    output logic signed [DW-1:0] top_re,
    output logic signed [DW-1:0] top_im,
    output logic signed [DW-1:0] bot_re,
    output logic signed [DW-1:0] bot_im
);
    import fft_pkg::*;

    localparam int PROD_W = DW + INV_SQRT2_SHIFT + 1;

    // Constant multiply by 181/256 built from the set bits of the numerator (shift-add only).
    function automatic logic signed [DW-1:0] mul_alpha(input logic signed [DW-1:0] v);
        logic signed [PROD_W-1:0] ext;
        logic signed [PROD_W-1:0] acc;
        ext = PROD_W'(v);
        acc = '0;
        for (int i = 0; i <= INV_SQRT2_SHIFT; i++) begin
            if (INV_SQRT2_NUM[i]) begin
                acc = acc + (ext <<< i);
            end
        end
        return DW'(acc >>> INV_SQRT2_SHIFT);
    endfunction

    logic signed [DW-1:0] diff_re, diff_im;
    logic signed [DW-1:0] m_sum, m_dif, m_nsum, m_ndif;

    assign diff_re = a_re - b_re;
    assign diff_im = a_im - b_im;
    assign top_re  = a_re + b_re;
    assign top_im  = a_im + b_im;

    // alpha*(r+i), alpha*(r-i) and their negations cover every odd twiddle in both directions.
    assign m_sum  = mul_alpha(diff_re + diff_im);
    assign m_dif  = mul_alpha(diff_re - diff_im);
    assign m_nsum = mul_alpha(-(diff_re + diff_im));
    assign m_ndif = mul_alpha(diff_im - diff_re);

    always_comb begin
        bot_re = diff_re;
        bot_im = diff_im;
        case (tw_idx)
            2'd1: begin
                bot_re = inverse ? m_dif : m_sum;
                bot_im = inverse ? m_sum : m_ndif;
            end
            2'd2: begin
                bot_re = inverse ? -diff_im : diff_im;
                bot_im = inverse ? diff_re  : -diff_re;
            end
            2'd3: begin
                bot_re = inverse ? m_nsum : m_ndif;
                bot_im = inverse ? m_dif  : m_nsum;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ifft8_core.sv
// 8-point iterative radix-2 DIF inverse FFT: one shared butterfly, 12 butterfly cycles,
// bit-reversed readout with round-half-up scaling by 1/8 and saturation to OUT_W bits.
module ifft8_core #(
    parameter int DATA_W      = fft_pkg::DATA_W,
    parameter int OUT_W       = fft_pkg::OUT_W,
    parameter int SCALE_SHIFT = fft_pkg::SCALE_SHIFT
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic signed [DATA_W-1:0] i_X0_re,
    input  logic signed [DATA_W-1:0] i_X1_re,
    input  logic signed [DATA_W-1:0] i_X2_re,
    input  logic signed [DATA_W-1:0] i_X3_re,
    input  logic signed [DATA_W-1:0] i_X4_re,
    input  logic signed [DATA_W-1:0] i_X5_re,
    input  logic signed [DATA_W-1:0] i_X6_re,
    input  logic signed [DATA_W-1:0] i_X7_re,
    input  logic signed [DATA_W-1:0] i_X0_im,
    input  logic signed [DATA_W-1:0] i_X1_im,
    input  logic signed [DATA_W-1:0] i_X2_im,
    input  logic signed [DATA_W-1:0] i_X3_im,
    input  logic signed [DATA_W-1:0] i_X4_im,
    input  logic signed [DATA_W-1:0] i_X5_im,
    input  logic signed [DATA_W-1:0] i_X6_im,
    input  logic signed [DATA_W-1:0] i_X7_im,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_sat,
    output logic signed [OUT_W-1:0]  o_x0,
    output logic signed [OUT_W-1:0]  o_x1,
    output logic signed [OUT_W-1:0]  o_x2,
    output logic signed [OUT_W-1:0]  o_x3,
    output logic signed [OUT_W-1:0]  o_x4,
    output logic signed [OUT_W-1:0]  o_x5,
    output logic signed [OUT_W-1:0]  o_x6,
    output logic signed [OUT_W-1:0]  o_x7
);
    import fft_pkg::*;

    localparam logic signed [DATA_W-1:0] SAT_MAX     = DATA_W'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [DATA_W-1:0] SAT_MIN     = DATA_W'(-(1 <<< (OUT_W - 1)));
    localparam logic signed [OUT_W-1:0]  SAT_MAX_OUT = OUT_W'(SAT_MAX);
    localparam logic signed [OUT_W-1:0]  SAT_MIN_OUT = OUT_W'(SAT_MIN);
    localparam logic signed [DATA_W-1:0] ROUND_BIAS  = DATA_W'(1 <<< (SCALE_SHIFT - 1));

    logic signed [DATA_W-1:0] in_re [N];
    logic signed [DATA_W-1:0] in_im [N];

    assign in_re[0] = i_X0_re;  assign in_im[0] = i_X0_im;
    assign in_re[1] = i_X1_re;  assign in_im[1] = i_X1_im;
    assign in_re[2] = i_X2_re;  assign in_im[2] = i_X2_im;
    assign in_re[3] = i_X3_re;  assign in_im[3] = i_X3_im;
    assign in_re[4] = i_X4_re;  assign in_im[4] = i_X4_im;
    assign in_re[5] = i_X5_re;  assign in_im[5] = i_X5_im;
    assign in_re[6] = i_X6_re;  assign in_im[6] = i_X6_im;
    assign in_re[7] = i_X7_re;  assign in_im[7] = i_X7_im;

    fft_state_t               state_reg, state_next;
    logic [1:0]               stage_reg, bfly_reg;
    logic                     busy_reg, done_reg, sat_reg;
    logic signed [DATA_W-1:0] re_reg [N];
    logic signed [DATA_W-1:0] im_reg [N];
    logic signed [OUT_W-1:0]  xn_reg [N];

    logic [LOG2N-1:0]         top_idx, bot_idx;
    logic [1:0]               tw_idx;
    logic                     last_bfly;
    logic signed [DATA_W-1:0] top_re, top_im, bot_re, bot_im;

    assign last_bfly = (stage_reg == 2'd2) && (bfly_reg == 2'd3);

    // Pair and twiddle selection for the current stage/butterfly.
    always_comb begin
        top_idx = {1'b0, bfly_reg};
        bot_idx = {1'b1, bfly_reg};
        tw_idx  = bfly_reg;
        case (stage_reg)
            2'd1: begin
                top_idx = {bfly_reg[1], 1'b0, bfly_reg[0]};
                bot_idx = {bfly_reg[1], 1'b1, bfly_reg[0]};
                tw_idx  = {bfly_reg[0], 1'b0};
            end
            2'd2: begin
                top_idx = {bfly_reg, 1'b0};
                bot_idx = {bfly_reg, 1'b1};
                tw_idx  = 2'd0;
            end
            default: ;
        endcase
    end

    fft_bfly_r2 #(.DW(DATA_W)) u_bfly (
        .a_re    (re_reg[top_idx]),
        .a_im    (im_reg[top_idx]),
        .b_re    (re_reg[bot_idx]),
        .b_im    (im_reg[bot_idx]),
        .tw_idx  (tw_idx),
        .inverse (1'b1),
        .top_re  (top_re),
        .top_im  (top_im),
        .bot_re  (bot_re),
        .bot_im  (bot_im)
    );

    // Output stage: bit-reversed slot, round half up, clamp.
    logic signed [OUT_W-1:0] sample_next [N];
    logic [N-1:0]            clip_flag;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_out
            logic signed [DATA_W-1:0] rounded;
            logic                     clip_hi, clip_lo;
            assign rounded          = (re_reg[bitrev3(LOG2N'(gi))] + ROUND_BIAS) >>> SCALE_SHIFT;
            assign clip_hi          = rounded > SAT_MAX;
            assign clip_lo          = rounded < SAT_MIN;
            assign clip_flag[gi]    = clip_hi | clip_lo;
            assign sample_next[gi]  = clip_hi ? SAT_MAX_OUT :
                                      clip_lo ? SAT_MIN_OUT : rounded[OUT_W-1:0];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (i_start) state_next = ST_RUN;
            ST_RUN:  if (last_bfly) state_next = ST_OUT;
            ST_OUT:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sat_reg   <= 1'b0;
            stage_reg <= 2'd0;
            bfly_reg  <= 2'd0;
            for (int i = 0; i < N; i++) begin
                re_reg[i] <= '0;
                im_reg[i] <= '0;
                xn_reg[i] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        for (int i = 0; i < N; i++) begin
                            re_reg[i] <= in_re[i];
                            im_reg[i] <= in_im[i];
                        end
                        stage_reg <= 2'd0;
                        bfly_reg  <= 2'd0;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // In-place update: both results land back in the slots they were read from.
                    re_reg[top_idx] <= top_re;
                    im_reg[top_idx] <= top_im;
                    re_reg[bot_idx] <= bot_re;
                    im_reg[bot_idx] <= bot_im;
                    bfly_reg        <= bfly_reg + 2'd1;
                    if (last_bfly) begin
                        stage_reg <= 2'd0;
                    end else if (bfly_reg == 2'd3) begin
                        stage_reg <= stage_reg + 2'd1;
                    end
                end
                ST_OUT: begin
                    for (int i = 0; i < N; i++) begin
                        xn_reg[i] <= sample_next[i];
                    end
                    sat_reg  <= |clip_flag;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = busy_reg;
    assign o_done = done_reg;
    assign o_sat  = sat_reg;
    assign o_x0   = xn_reg[0];
    assign o_x1   = xn_reg[1];
    assign o_x2   = xn_reg[2];
    assign o_x3   = xn_reg[3];
    assign o_x4   = xn_reg[4];
    assign o_x5   = xn_reg[5];
    assign o_x6   = xn_reg[6];
    assign o_x7   = xn_reg[7];

endmodule

// File: tb/tb_ifft8_core.sv
// Scoreboard bench for ifft8_core: driver queues expected samples, monitor checks on o_done.
module tb_ifft8_core;

    logic               clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_start = 1'b0;
    logic signed [31:0] xre [8];
    logic signed [31:0] xim [8];
    logic               o_busy, o_done, o_sat;
    logic signed [20:0] xn [8];

    int n_checks = 0;
    int n_pass   = 0;

    int vre [8];
    int vim [8];
    int vexp [8];

    int    exp_x_q [$];
    bit    sat_q   [$];
    int    tol_q   [$];
    string name_q  [$];

    always #5 clk = ~clk;

    ifft8_core dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_X0_re (xre[0]), .i_X1_re (xre[1]), .i_X2_re (xre[2]), .i_X3_re (xre[3]),
        .i_X4_re (xre[4]), .i_X5_re (xre[5]), .i_X6_re (xre[6]), .i_X7_re (xre[7]),
        .i_X0_im (xim[0]), .i_X1_im (xim[1]), .i_X2_im (xim[2]), .i_X3_im (xim[3]),
        .i_X4_im (xim[4]), .i_X5_im (xim[5]), .i_X6_im (xim[6]), .i_X7_im (xim[7]),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sat   (o_sat),
        .o_x0    (xn[0]), .o_x1 (xn[1]), .o_x2 (xn[2]), .o_x3 (xn[3]),
        .o_x4    (xn[4]), .o_x5 (xn[5]), .o_x6 (xn[6]), .o_x7 (xn[7])
    );

    task automatic check_val(input string name, input int act, input int exp, input int tol);
        int d;
        d = act - exp;
        n_checks++;
        if (d <= tol && d >= -tol) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Monitor: pops one expected transform per o_done pulse.
    always @(negedge clk) begin
        if (o_done) begin
            if (name_q.size() == 0) begin
                check_val("unexpected_done", 1, 0, 0);
            end else begin
                string nm;
                bit    es;
                int    tl;
                nm = name_q.pop_front();
                es = sat_q.pop_front();
                tl = tol_q.pop_front();
                $display("[%0t] %s: x=%0d %0d %0d %0d %0d %0d %0d %0d sat=%0d", $time, nm,
                         xn[0], xn[1], xn[2], xn[3], xn[4], xn[5], xn[6], xn[7], o_sat);
                for (int n = 0; n < 8; n++) begin
                    check_val($sformatf("%s_x%0d", nm, n), int'(xn[n]), exp_x_q.pop_front(), tl);
                end
                check_val($sformatf("%s_sat", nm), int'(o_sat), int'(es), 0);
            end
        end
    end

    // Presents vre/vim at a negedge with i_start, returns at the negedge after the start edge.
    task automatic issue(input string name, input bit push, input bit exp_sat, input int tol);
        for (int i = 0; i < 8; i++) begin
            xre[i] = vre[i];
            xim[i] = vim[i];
        end
        if (push) begin
            for (int i = 0; i < 8; i++) exp_x_q.push_back(vexp[i]);
            sat_q.push_back(exp_sat);
            tol_q.push_back(tol);
            name_q.push_back(name);
        end
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            xre[i] = $urandom;
            xim[i] = $urandom;
        end
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (!o_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_val($sformatf("%s_done_seen", name), int'(o_done), 1, 0);
        @(negedge clk);
    endtask

    task automatic run_vec(input string name, input bit exp_sat, input int tol);
        issue(name, 1'b1, exp_sat, tol);
        wait_done(name);
    endtask

    initial begin
        int dones;
        for (int i = 0; i < 8; i++) begin
            xre[i] = 0;
            xim[i] = 0;
        end

        // Reset held for three edges, then idle.
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            int any;
            @(negedge clk);
            any = int'(o_busy) | int'(o_done) | int'(o_sat);
            for (int n = 0; n < 8; n++) any = any | int'(xn[n] != 0);
            check_val($sformatf("idle_quiet_c%0d", c), any, 0, 0);
        end

        // DC spectrum with cycle-exact handshake timing.
        vre = '{800, 0, 0, 0, 0, 0, 0, 0};
        vim = '{0, 0, 0, 0, 0, 0, 0, 0};
        vexp = '{100, 100, 100, 100, 100, 100, 100, 100};
        issue("dc", 1'b1, 1'b0, 0);
        for (int k = 1; k <= 15; k++) begin
            check_val($sformatf("dc_busy_T%0d", k), int'(o_busy), int'(k <= 13), 0);
            check_val($sformatf("dc_done_T%0d", k), int'(o_done), int'(k == 14), 0);
            @(negedge clk);
        end

        vre = '{8000, 8000, 8000, 8000, 8000, 8000, 8000, 8000};
        vim = '{0, 0, 0, 0, 0, 0, 0, 0};
        vexp = '{8000, 0, 0, 0, 0, 0, 0, 0};
        run_vec("flat", 1'b0, 0);

        vre = '{0, 4000, 0, 0, 0, 0, 0, 4000};
        vim = '{0, 0, 0, 0, 0, 0, 0, 0};
        vexp = '{1000, 707, 0, -707, -1000, -707, 0, 707};
        run_vec("cosine", 1'b0, 2);

        // Rounded forward DFT of x = [100,-50,3,0,7,-8,1000,-1000].
        vre = '{52, -644, -896, 830, 2168, 830, -896, -644};
        vim = '{0, 320, -942, -1674, 0, 1674, 942, -320};
        vexp = '{100, -50, 3, 0, 7, -8, 1000, -1000};
        run_vec("roundtrip", 1'b0, 2);

        vre = '{268435455, 0, 0, 0, 0, 0, 0, 0};
        vim = '{0, 0, 0, 0, 0, 0, 0, 0};
        vexp = '{1048575, 1048575, 1048575, 1048575, 1048575, 1048575, 1048575, 1048575};
        run_vec("sat_pos", 1'b1, 0);

        vre = '{-134217728, 0, 0, 0, 0, 0, 0, 0};
        vexp = '{-1048576, -1048576, -1048576, -1048576, -1048576, -1048576, -1048576, -1048576};
        run_vec("sat_neg", 1'b1, 0);

        // Start pulse at T+5 while running must be ignored.
        vre = '{800, 0, 0, 0, 0, 0, 0, 0};
        vexp = '{100, 100, 100, 100, 100, 100, 100, 100};
        issue("start_ignored", 1'b1, 1'b0, 0);
        dones = 0;
        repeat (4) begin
            dones += int'(o_done);
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) xre[i] = 5555;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            dones += int'(o_done);
            @(negedge clk);
        end
        check_val("start_ignored_done_count", dones, 1, 0);

        // Reset at T+6 aborts: busy drops next cycle, outputs cleared, no done.
        vre = '{0, 4000, 0, 0, 0, 0, 0, 4000};
        issue("abort", 1'b0, 1'b0, 0);
        repeat (5) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check_val("abort_busy", int'(o_busy), 0, 0);
        check_val("abort_x0_cleared", int'(xn[0]), 0, 0);
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            dones += int'(o_done);
            @(negedge clk);
        end
        check_val("abort_done_count", dones, 0, 0);

        check_val("scoreboard_drained", name_q.size(), 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
